dbus_arbiter: RTL

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter onto a single-port synchronous memory.
// Round-robin, with an optional m1 lock mode (DBUS_ARB_LOCK_EN) that
// lets m0 through after HOLD_MAX consecutive denials.
// Ports: clk_i, rst_i (async, active-low); per master mN_req_i/we_i/
// addr_i/wdata_i/be_i in, mN_gnt_o/rvalid_o/rdata_o out; m1_lock_i;
// memory side s_cs_o/we_o/addr_o/wdata_o/be_o out, s_rdata_i in.
module dbus_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [31:0]       m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic [3:0]        m0_be_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [31:0]       m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  input  logic [3:0]        m1_be_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  input  logic              m1_lock_i,
  output logic              s_cs_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [31:0]       s_wdata_o,
  output logic [3:0]        s_be_o,
  input  logic [31:0]       s_rdata_i
);

  // 1 = m1 was granted most recently
  logic       r_last_gnt;
  logic       r_m0_rvalid;
  logic       r_m1_rvalid;
  logic       w_rr_m0;
  logic       w_rr_m1;
  logic       w_m0_gnt;
  logic       w_m1_gnt;
  logic       w_we;
  logic [3:0] w_hold_lim;
  logic       w_unused;

  assign w_hold_lim = 4'(HOLD_MAX);

  assign w_unused = ^{m1_lock_i, w_hold_lim,
                      m0_addr_i[31:ADDR_W+2], m0_addr_i[1:0],
                      m1_addr_i[31:ADDR_W+2], m1_addr_i[1:0]};

  // conflict goes to the master not granted last
  assign w_rr_m0 = m0_req_i & (~m1_req_i | r_last_gnt);
  assign w_rr_m1 = m1_req_i & (~m0_req_i | ~r_last_gnt);

`ifdef DBUS_ARB_LOCK_EN
  typedef enum logic {RR, LOCKED} state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_hold_cnt;
  logic [3:0] w_next_hold;
  logic       w_lock_act;

  // lock only holds while m1 keeps both lock and req up
  assign w_lock_act = (r_state == LOCKED) & m1_lock_i & m1_req_i;

  always_comb begin
    w_m0_gnt     = 1'b0;
    w_m1_gnt     = 1'b0;
    w_next_state = r_state;
    w_next_hold  = r_hold_cnt;
    if (w_lock_act) begin
      if (m0_req_i && (r_hold_cnt == w_hold_lim)) begin
        w_m0_gnt    = 1'b1;
        w_next_hold = 4'd0;
      end else begin
        w_m1_gnt = 1'b1;
        if (m0_req_i)
          w_next_hold = r_hold_cnt + 4'd1;
      end
    end else begin
      w_m0_gnt     = w_rr_m0;
      w_m1_gnt     = w_rr_m1;
      w_next_hold  = 4'd0;
      w_next_state = (w_rr_m1 & m1_lock_i) ? LOCKED : RR;
    end
    if (!rst_i) begin
      w_m0_gnt = 1'b0;
      w_m1_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= RR;
      r_hold_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_hold_cnt <= w_next_hold;
    end
  end
`else
  assign w_m0_gnt = w_rr_m0 & rst_i;
  assign w_m1_gnt = w_rr_m1 & rst_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last_gnt  <= 1'b1;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      if (w_m0_gnt | w_m1_gnt)
        r_last_gnt <= w_m1_gnt;
      r_m0_rvalid <= w_m0_gnt & ~m0_we_i;
      r_m1_rvalid <= w_m1_gnt & ~m1_we_i;
    end
  end

  assign w_we = (w_m0_gnt & m0_we_i) | (w_m1_gnt & m1_we_i);

  assign m0_gnt_o    = w_m0_gnt;
  assign m1_gnt_o    = w_m1_gnt;
  assign m0_rvalid_o = r_m0_rvalid;
  assign m1_rvalid_o = r_m1_rvalid;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  assign s_cs_o    = w_m0_gnt | w_m1_gnt;
  assign s_we_o    = w_we;
  assign s_addr_o  = w_m1_gnt ? m1_addr_i[ADDR_W+1:2]
                              : m0_addr_i[ADDR_W+1:2];
  assign s_wdata_o = w_m1_gnt ? m1_wdata_i : m0_wdata_i;
  assign s_be_o    = (w_m1_gnt ? m1_be_i : m0_be_i) & {4{w_we}};

endmodule
